spike_aer_encoder: RTL and testbench
====================================

// Module: spike_aer_encoder
// PURPOSE
//  Consumes the concatenated spike-vector stream from the network (one beat per neuron block:
//  tdata = N spike bits, tuser = block index, tlast = last block of the time step).
//  Serialises each beat into address-event (AER) words: one word per set spike bit, lowest index
//  first, tagged with the current time-step number.
//  Sits directly downstream of the network, upstream of the host/DMA event sink.
// PARAMETERS
//  N    16  spike bits per beat (neurons per block)
//  T    4   neuron blocks per time step; U = $clog2(T) (min 1)
//  TSW  16  time-step counter width
//  CW   16  per-time-step event counter width
// PORTS
//  clk          in   1        clock
//  reset        in   1        reset, synchronous, active-high
//  s_tvalid     in   1        input beat valid
//  s_tready     out  1        input beat accepted
//  s_tdata      in   N        spike vector
//  s_tuser      in   U        block index of beat
//  s_tlast      in   1        last beat of time step
//  m_tvalid     out  1        event valid
//  m_tready     in   1        event accepted
//  m_tdata      out  U+$clog2(N)  event address {block, neuron}
//  m_tuser      out  TSW      time step of event
//  m_tlast      out  1        last event of time step
//  ts_event_cnt out  CW       events emitted in last completed time step (saturating)
//  ts_done      out  1        1-cycle pulse when a tlast beat is fully drained
// BEHAVIOUR
//  Reset values: s_tready=1, m_tvalid=0, m_tdata=0, m_tuser=0, m_tlast=0, ts_event_cnt=0,
//   ts_done=0, time-step counter=0, mask=0, state=IDLE. Reset mid-beat discards all pending events.
//  FSM IDLE: s_tready=1. On s_tvalid&s_tready: latch tdata->mask, tuser->blk, tlast->last.
//   mask!=0 -> SCAN. mask==0 -> stay IDLE; if last: ts_done pulse, ts counter +1 (mod 2^TSW),
//   ts_event_cnt <= running count, running count <= 0.
//  FSM SCAN: m_tvalid=1, m_tdata={blk, index of lowest set mask bit}, m_tuser=ts counter,
//   m_tlast = last & (exactly one mask bit set). Output registered and stable while m_tvalid&!m_tready.
//   On m_tvalid&m_tready: clear that bit, running count +1 (saturate at 2^CW-1).
//   When final bit is taken: if last, do ts bookkeeping as in IDLE (ts_done same cycle as final handshake).
//   s_tready = (state==SCAN) & final bit & m_tready; a beat accepted then is latched the same cycle
//   -> back-to-back beats, no bubble. Otherwise s_tready=0 in SCAN.
//  Latency: beat accepted cycle 0 -> first event m_tvalid cycle 1. Throughput 1 event/cycle.
//  Zero-spike beat consumes 1 cycle; s_tready stays 1.
//  Time-step counter wraps 2^TSW-1 -> 0; events after wrap carry m_tuser=0.
//  m_tready low: holds state, no bits lost; s_tready=0 applies backpressure upstream.
//  s_tuser is not checked against expected order; it is passed through.
// CONFIGURATION
//  SPIKE_AER_EMPTY_MARKER_EN
//   defined: a tlast beat with mask==0 enters SCAN for one marker event: m_tdata all-ones,
//    m_tlast=1, not counted in ts_event_cnt; ts bookkeeping occurs on its handshake.
//    Guarantees every time step ends with an m_tlast event.
//   undefined: a zero-spike tlast beat emits nothing; the step is visible only via ts_done.
// STRUCTURE
//  snn_pkg: typedef aer_event_t {block, neuron} address struct; localparam AER_AW = U+$clog2(N);
//   enum spike_aer_state_t {IDLE, SCAN}.
//  Sub-module spike_priority_encoder #(N): comb lowest-set-bit index + onehot + "single bit" flag.
//  Top: FSM, mask/blk/last registers, ts counter, event counters, output registers.
// TESTING
//  1 beat tdata=16'h8101 tuser=2 tlast=1, m_tready=1 -> events {2,0},{2,8},{2,15} cycles 1..3,
//    m_tlast only on {2,15}, m_tuser=0, ts_done cycle 3, ts_event_cnt=3.
//  4 beats 16'h0001 tuser=0..3 back-to-back, last on beat 3 -> 4 events in 4 consecutive cycles,
//    s_tready never drops; next step events carry m_tuser=1.
//  m_tready toggled 1-0-1 on 16'hFFFF -> 16 events in order 0..15, each held stable while stalled.
//  tlast beat tdata=0: without macro -> no event, ts_done 1 cycle later, count 0;
//    with SPIKE_AER_EMPTY_MARKER_EN -> one all-ones event with m_tlast=1.
//  Reset asserted after 2 of 5 events -> outputs at reset values next cycle, none of remaining 3 emitted.
//  Preload ts counter near 2^TSW-1 (TSW=4: 16 steps) -> 17th step events carry m_tuser=0.

Source files
------------

// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snn_pkg
// Purpose  : Shared types and constants for the spike-to-AER encoder slice.
//            The address layout and widths below reflect the default build
//            (16 neurons per block, 4 blocks per time step). Parameterised
//            modules derive their own widths from their parameters.
// Contents : AER_AW            default event address width
//            aer_event_t       {block, neuron} address layout
//            spike_aer_state_t encoder FSM states
// Revision : 1.0  initial release
// ============================================================================
package snn_pkg;

  localparam int SNN_N  = 16;
  localparam int SNN_T  = 4;
  localparam int SNN_U  = (SNN_T > 1) ? $clog2(SNN_T) : 1;
  localparam int SNN_NW = (SNN_N > 1) ? $clog2(SNN_N) : 1;
  localparam int AER_AW = SNN_U + SNN_NW;

  typedef struct packed {
    logic [SNN_U-1:0]  block;
    logic [SNN_NW-1:0] neuron;
  } aer_event_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } spike_aer_state_t;

endpackage
`default_nettype wire

// File: rtl/spike_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module   : spike_priority_encoder
// Purpose  : Combinational lowest-set-bit finder for a spike mask.
// Ports    : vec     in  N   spike mask
//            index   out IW  index of lowest set bit (0 when vec==0)
//            onehot  out N   isolated lowest set bit (0 when vec==0)
//            single  out 1   exactly one bit of vec is set
// Revision : 1.0  initial release
// ============================================================================
module spike_priority_encoder #(
  parameter int N  = 16,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] index,
  output logic [N-1:0]  onehot,
  output logic          single
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) index = IW'(i);
    end
  end

  // Two's-complement trick: x & -x isolates the lowest set bit.
  assign onehot = vec & (~vec + N'(1));

  // x & (x-1) clears the lowest set bit; zero result means at most one bit.
  assign single = (vec != '0) && ((vec & (vec - N'(1))) == '0);

endmodule
`default_nettype wire

// File: rtl/spike_aer_encoder.sv
`default_nettype none
// ============================================================================
// Module   : spike_aer_encoder
// Purpose  : Serialises spike-vector beats into address-event words, one per
//            set spike bit, lowest index first, tagged with the time step.
// Ports    : clk, reset          clock, synchronous active-high reset
//            s_tvalid/s_tready   spike beat handshake
//            s_tdata [N]         spike vector
//            s_tuser [U]         block index of the beat
//            s_tlast             last beat of the time step
//            m_tvalid/m_tready   event handshake
//            m_tdata [AW]        event address {block, neuron}
//            m_tuser [TSW]       time step of the event
//            m_tlast             last event of the time step
//            ts_event_cnt [CW]   events in last completed step (saturating)
//            ts_done             pulse when a step's final beat is drained
// Config   : SPIKE_AER_EMPTY_MARKER_EN - a zero-spike tlast beat emits one
//            all-ones marker event with m_tlast=1 (not counted).
// Revision : 1.0  initial release
// ============================================================================
module spike_aer_encoder
  import snn_pkg::*;
#(
  parameter int N   = 16,
  parameter int T   = 4,
  parameter int TSW = 16,
  parameter int CW  = 16,
  localparam int U  = (T > 1) ? $clog2(T) : 1,
  localparam int NW = (N > 1) ? $clog2(N) : 1,
  localparam int AW = U + NW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s_tvalid,
  output logic           s_tready,
  input  logic [N-1:0]   s_tdata,
  input  logic [U-1:0]   s_tuser,
  input  logic           s_tlast,
  output logic           m_tvalid,
  input  logic           m_tready,
  output logic [AW-1:0]  m_tdata,
  output logic [TSW-1:0] m_tuser,
  output logic           m_tlast,
  output logic [CW-1:0]  ts_event_cnt,
  output logic           ts_done
);

  spike_aer_state_t state, state_nx;

  logic [N-1:0]   mask;
  logic [U-1:0]   blk;
  logic           last;
  logic [TSW-1:0] ts_cnt;
  logic [CW-1:0]  run_cnt;
  logic [CW-1:0]  ts_event_cnt_r;
  // Set when a zero-spike step-ending beat was absorbed without events;
  // its step bookkeeping completes on the following cycle.
  logic           pend;

  logic [NW-1:0]  pe_index;
  logic [N-1:0]   pe_onehot;
  logic           pe_single;

  logic           is_marker;
  logic           final_bit;
  logic           acc;
  logic           take;
  logic           final_take;
  logic           beat_scan;
  logic           beat_pend;
  logic           bk_scan;
  logic [CW-1:0]  cnt_inc;

  spike_priority_encoder #(
    .N  (N),
    .IW (NW)
  ) u_pe (
    .vec    (mask),
    .index  (pe_index),
    .onehot (pe_onehot),
    .single (pe_single)
  );

`ifdef SPIKE_AER_EMPTY_MARKER_EN
  // A SCAN state with an empty mask only arises from an empty step-ending beat.
  assign is_marker = (state == SCAN) && (mask == '0);
  assign beat_scan = (s_tdata != '0) || s_tlast;
  assign beat_pend = 1'b0;
`else
  assign is_marker = 1'b0;
  assign beat_scan = (s_tdata != '0);
  assign beat_pend = (s_tdata == '0) && s_tlast;
`endif

  assign final_bit  = pe_single || is_marker;
  assign take       = (state == SCAN) && m_tready;
  assign final_take = take && final_bit;
  assign acc        = s_tvalid && s_tready;
  assign bk_scan    = final_take && last;
  assign cnt_inc    = is_marker ? run_cnt :
                      (run_cnt == '1) ? run_cnt : run_cnt + CW'(1);

  // ---------------------------------------------------------------- FSM ---
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (acc && beat_scan) state_nx = SCAN;
      SCAN: if (final_take) state_nx = (acc && beat_scan) ? SCAN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded purely from registered state, so they hold steady
  // while the sink stalls; only s_tready/ts_done also look at m_tready.
  always_comb begin
    s_tready = (state == IDLE) || final_take;
    m_tvalid = (state == SCAN);
    m_tdata  = is_marker ? {AW{1'b1}} : {blk, pe_index};
    m_tuser  = ts_cnt;
    m_tlast  = (state == SCAN) && last && final_bit;
    ts_done  = bk_scan || pend;
  end

  // ----------------------------------------------------------- datapath ---
  always_ff @(posedge clk) begin
    if (reset) begin
      mask           <= '0;
      blk            <= '0;
      last           <= 1'b0;
      ts_cnt         <= '0;
      run_cnt        <= '0;
      ts_event_cnt_r <= '0;
      pend           <= 1'b0;
    end else begin
      // A beat accepted on the final handshake replaces the exhausted mask.
      if (acc) begin
        mask <= s_tdata;
        blk  <= s_tuser;
        last <= s_tlast;
      end else if (take) begin
        mask <= mask & ~pe_onehot;
      end

      pend <= acc && beat_pend;

      // pend implies IDLE, so it never coincides with bk_scan.
      if (bk_scan || pend) begin
        ts_cnt         <= ts_cnt + TSW'(1);
        ts_event_cnt_r <= bk_scan ? cnt_inc : run_cnt;
        run_cnt        <= '0;
      end else if (take) begin
        run_cnt <= cnt_inc;
      end
    end
  end

  assign ts_event_cnt = ts_event_cnt_r;

endmodule
`default_nettype wire

// File: tb/tb_spike_aer_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_aer_encoder
// Purpose  : Directed self-checking bench for spike_aer_encoder with
//            N=16, T=4, TSW=4, CW=16.
// Revision : 1.0  initial release
// ============================================================================
module tb_spike_aer_encoder;

  localparam int N   = 16;
  localparam int T   = 4;
  localparam int TSW = 4;
  localparam int CW  = 16;
  localparam int U   = 2;
  localparam int AW  = 6;

  logic           clk = 1'b0;
  logic           reset;
  logic           s_tvalid;
  logic           s_tready;
  logic [N-1:0]   s_tdata;
  logic [U-1:0]   s_tuser;
  logic           s_tlast;
  logic           m_tvalid;
  logic           m_tready;
  logic [AW-1:0]  m_tdata;
  logic [TSW-1:0] m_tuser;
  logic           m_tlast;
  logic [CW-1:0]  ts_event_cnt;
  logic           ts_done;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  // {m_tvalid, m_tlast, m_tdata, m_tuser}
  logic [11:0] obs;
  assign obs = {m_tvalid, m_tlast, m_tdata, m_tuser};

  spike_aer_encoder #(
    .N   (N),
    .T   (T),
    .TSW (TSW),
    .CW  (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tdata      (s_tdata),
    .s_tuser      (s_tuser),
    .s_tlast      (s_tlast),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tdata      (m_tdata),
    .m_tuser      (m_tuser),
    .m_tlast      (m_tlast),
    .ts_event_cnt (ts_event_cnt),
    .ts_done      (ts_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus helper: offers one beat and waits (bounded) for acceptance.
  task automatic send_beat(input logic [N-1:0] d, input logic [U-1:0] u, input logic l);
    int w;
    w = 0;
    s_tvalid = 1'b1; s_tdata = d; s_tuser = u; s_tlast = l;
    #1;
    while (!s_tready && w < 20) begin
      tick(); #1; w++;
    end
    cmp_cnt++;
    if (s_tready !== 1'b1) begin
      fail_cnt++; $display("FAIL send_beat_timeout s_tready got %0b want 1", s_tready);
    end
    tick();
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tuser = '0; s_tlast = 1'b0; m_tready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    cmp_cnt++;
    if ({s_tready, obs, ts_event_cnt, ts_done} !== {1'b1, 12'h000, 16'h0000, 1'b0}) begin
      fail_cnt++;
      $display("FAIL reset_values got rdy=%0b obs=%h cnt=%0d done=%0b want rdy=1 obs=000 cnt=0 done=0",
               s_tready, obs, ts_event_cnt, ts_done);
    end
  endtask

  task automatic test_single_beat();
    logic [3:0] nrn;
    m_tready = 1'b1;
    s_tvalid = 1'b1; s_tdata = 16'h8101; s_tuser = 2'd2; s_tlast = 1'b1;
    #1;
    cmp_cnt++;
    if (s_tready !== 1'b1) begin
      fail_cnt++; $display("FAIL single_accept s_tready got %0b want 1", s_tready);
    end
    tick();
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nrn = (k == 0) ? 4'd0 : (k == 1) ? 4'd8 : 4'd15;
      #1;
      cmp_cnt++;
      if ({obs, ts_done} !== {1'b1, (k == 2), 2'd2, nrn, 4'd0, (k == 2)}) begin
        fail_cnt++;
        $display("FAIL single_event%0d got obs=%h done=%0b want obs=%h done=%0b", k, obs, ts_done,
                 {1'b1, (k == 2), 2'd2, nrn, 4'd0}, (k == 2));
      end
      tick();
    end
    #1;
    cmp_cnt++;
    if ({m_tvalid, ts_done, ts_event_cnt} !== {1'b0, 1'b0, 16'd3}) begin
      fail_cnt++;
      $display("FAIL single_after got vld=%0b done=%0b cnt=%0d want vld=0 done=0 cnt=3",
               m_tvalid, ts_done, ts_event_cnt);
    end
  endtask

  task automatic test_back_to_back();
    m_tready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        s_tvalid = 1'b1; s_tdata = 16'h0001; s_tuser = 2'(k); s_tlast = (k == 3);
      end else begin
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
      end
      #1;
      if (k < 4) begin
        cmp_cnt++;
        if (s_tready !== 1'b1) begin
          fail_cnt++; $display("FAIL b2b_ready%0d got %0b want 1", k, s_tready);
        end
      end
      if (k >= 1) begin
        cmp_cnt++;
        if ({obs, ts_done} !== {1'b1, (k == 4), 2'(k - 1), 4'd0, 4'd1, (k == 4)}) begin
          fail_cnt++;
          $display("FAIL b2b_event%0d got obs=%h done=%0b want obs=%h done=%0b", k - 1, obs, ts_done,
                   {1'b1, (k == 4), 2'(k - 1), 4'd0, 4'd1}, (k == 4));
        end
      end
      tick();
    end
    #1;
    cmp_cnt++;
    if ({m_tvalid, ts_event_cnt} !== {1'b0, 16'd4}) begin
      fail_cnt++;
      $display("FAIL b2b_after got vld=%0b cnt=%0d want vld=0 cnt=4", m_tvalid, ts_event_cnt);
    end
  endtask

  task automatic test_stall();
    int idx;
    int cyc;
    m_tready = 1'b1;
    s_tvalid = 1'b1; s_tdata = 16'hFFFF; s_tuser = 2'd1; s_tlast = 1'b1;
    tick();
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 16 && cyc < 64) begin
      m_tready = ((cyc % 3) != 1);
      #1;
      cmp_cnt++;
      if ({obs, s_tready, ts_done} !==
          {1'b1, (idx == 15), 2'd1, 4'(idx), 4'd2, (m_tready && idx == 15), (m_tready && idx == 15)}) begin
        fail_cnt++;
        $display("FAIL stall_event%0d cyc%0d got obs=%h rdy=%0b done=%0b want obs=%h", idx, cyc,
                 obs, s_tready, ts_done, {1'b1, (idx == 15), 2'd1, 4'(idx), 4'd2});
      end
      if (m_tready) idx++;
      tick();
      cyc++;
    end
    cmp_cnt++;
    if (idx !== 16) begin
      fail_cnt++; $display("FAIL stall_timeout events got %0d want 16", idx);
    end
    m_tready = 1'b1;
    #1;
    cmp_cnt++;
    if ({m_tvalid, ts_event_cnt} !== {1'b0, 16'd16}) begin
      fail_cnt++;
      $display("FAIL stall_after got vld=%0b cnt=%0d want vld=0 cnt=16", m_tvalid, ts_event_cnt);
    end
  endtask

  task automatic test_empty_step();
    m_tready = 1'b1;
    s_tvalid = 1'b1; s_tdata = 16'h0000; s_tuser = 2'd3; s_tlast = 1'b1;
    #1;
    cmp_cnt++;
    if (s_tready !== 1'b1) begin
      fail_cnt++; $display("FAIL empty_accept s_tready got %0b want 1", s_tready);
    end
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    #1;
`ifdef SPIKE_AER_EMPTY_MARKER_EN
    cmp_cnt++;
    if ({obs, ts_done} !== {1'b1, 1'b1, 6'h3F, 4'd3, 1'b1}) begin
      fail_cnt++;
      $display("FAIL empty_marker got obs=%h done=%0b want obs=%h done=1", obs, ts_done,
               {1'b1, 1'b1, 6'h3F, 4'd3});
    end
`else
    cmp_cnt++;
    if ({m_tvalid, ts_done} !== 2'b01) begin
      fail_cnt++;
      $display("FAIL empty_nomarker got vld=%0b done=%0b want vld=0 done=1", m_tvalid, ts_done);
    end
`endif
    tick();
    #1;
    cmp_cnt++;
    if ({m_tvalid, ts_done, ts_event_cnt} !== {1'b0, 1'b0, 16'd0}) begin
      fail_cnt++;
      $display("FAIL empty_after got vld=%0b done=%0b cnt=%0d want vld=0 done=0 cnt=0",
               m_tvalid, ts_done, ts_event_cnt);
    end
  endtask

  task automatic test_reset_midbeat();
    m_tready = 1'b1;
    s_tvalid = 1'b1; s_tdata = 16'h001F; s_tuser = 2'd0; s_tlast = 1'b1;
    tick();
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    #1;
    cmp_cnt++;
    if (obs !== {1'b1, 1'b0, 6'h00, 4'd4}) begin
      fail_cnt++; $display("FAIL midrst_event0 got obs=%h want %h", obs, {1'b1, 1'b0, 6'h00, 4'd4});
    end
    tick();
    #1;
    cmp_cnt++;
    if (obs !== {1'b1, 1'b0, 6'h01, 4'd4}) begin
      fail_cnt++; $display("FAIL midrst_event1 got obs=%h want %h", obs, {1'b1, 1'b0, 6'h01, 4'd4});
    end
    tick();
    m_tready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    cmp_cnt++;
    if ({s_tready, obs, ts_event_cnt, ts_done} !== {1'b1, 12'h000, 16'h0000, 1'b0}) begin
      fail_cnt++;
      $display("FAIL midrst_values got rdy=%0b obs=%h cnt=%0d done=%0b want rdy=1 obs=000 cnt=0 done=0",
               s_tready, obs, ts_event_cnt, ts_done);
    end
    m_tready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      cmp_cnt++;
      if ({m_tvalid, ts_done} !== 2'b00) begin
        fail_cnt++;
        $display("FAIL midrst_quiet%0d got vld=%0b done=%0b want 0 0", k, m_tvalid, ts_done);
      end
    end
  endtask

  task automatic test_ts_wrap();
    int w;
    m_tready = 1'b1;
    for (int s = 0; s < 15; s++) begin
      send_beat(16'h0000, 2'd0, 1'b1);
    end
    send_beat(16'h0004, 2'd0, 1'b1);
    #1;
    cmp_cnt++;
    if (obs !== {1'b1, 1'b1, 6'h02, 4'd15}) begin
      fail_cnt++; $display("FAIL wrap_step15 got obs=%h want %h", obs, {1'b1, 1'b1, 6'h02, 4'd15});
    end
    send_beat(16'h0002, 2'd0, 1'b1);
    #1;
    cmp_cnt++;
    if (obs !== {1'b1, 1'b1, 6'h01, 4'd0}) begin
      fail_cnt++; $display("FAIL wrap_step16 got obs=%h want %h", obs, {1'b1, 1'b1, 6'h01, 4'd0});
    end
    w = 0;
    while (m_tvalid && w < 10) begin
      tick(); #1; w++;
    end
    cmp_cnt++;
    if ({m_tvalid, ts_event_cnt} !== {1'b0, 16'd1}) begin
      fail_cnt++;
      $display("FAIL wrap_after got vld=%0b cnt=%0d want vld=0 cnt=1", m_tvalid, ts_event_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_stall();
    test_empty_step();
    test_reset_midbeat();
    test_ts_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
